// File: rtl/sym_vn_rank_dbuf.sv
// Double-buffered symmetric VN rank LUT: readers see the active half while the
// load FSM fills the shadow half page by page, then the halves swap in one cycle.
module sym_vn_rank_dbuf #(
   parameter int QUAN_SIZE     = 4,
   parameter int PAGE_ADDR_BW  = 6,
   parameter int BANK_NUM      = 2,
   parameter int BANK_BW       = 1,
   parameter int READ_PORT_NUM = 2
) (
   input  logic                                    write_clk,
   input  logic                                    rstn,
   input  logic [READ_PORT_NUM-1:0]                rd_en,
   input  logic [READ_PORT_NUM*BANK_BW-1:0]        rd_bank_addr,
   input  logic [READ_PORT_NUM*PAGE_ADDR_BW-1:0]   rd_page_addr,
   output logic [READ_PORT_NUM*QUAN_SIZE-1:0]      lut_data,
   input  logic                                    load_start,
   input  logic                                    load_abort,
   input  logic                                    load_valid,
   input  logic [BANK_NUM*QUAN_SIZE-1:0]           load_data,
   output logic                                    load_ready,
   output logic                                    load_done,
   output logic                                    active_half,
   output logic                                    busy
);

   localparam int                     PAGE_NUM  = 1 << PAGE_ADDR_BW;
   localparam logic [BANK_BW:0]       BANK_LIM  = (BANK_BW+1)'(BANK_NUM);
   localparam logic [PAGE_ADDR_BW-1:0] PAGE_ONE  = PAGE_ADDR_BW'(1);
   localparam logic [PAGE_ADDR_BW-1:0] PAGE_LAST = PAGE_ADDR_BW'(PAGE_NUM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COMMIT
   } state_t;

   state_t                  state_q, state_d;
   logic [PAGE_ADDR_BW-1:0] page_cnt_q, page_cnt_d;
   logic                    active_half_q, active_half_d;
   logic                    beat_we;

   logic [QUAN_SIZE-1:0]    mem_q [BANK_NUM][2][PAGE_NUM];
   logic [QUAN_SIZE-1:0]    lut_q [READ_PORT_NUM];
   logic [QUAN_SIZE-1:0]    rd_word [READ_PORT_NUM];
   logic [BANK_BW-1:0]      rd_bank [READ_PORT_NUM];
   logic [PAGE_ADDR_BW-1:0] rd_page [READ_PORT_NUM];

   // Abort outranks a beat presented in the same cycle; that beat is dropped.
   always_comb begin
      state_d       = state_q;
      page_cnt_d    = page_cnt_q;
      active_half_d = active_half_q;
      beat_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d    = S_LOAD;
               page_cnt_d = '0;
            end
         end
         S_LOAD: begin
            if (load_abort) begin
               state_d    = S_IDLE;
               page_cnt_d = '0;
            end else if (load_valid) begin
               beat_we    = 1'b1;
               page_cnt_d = page_cnt_q + PAGE_ONE;
               if (page_cnt_q == PAGE_LAST) begin
                  state_d = S_COMMIT;
               end
            end
         end
         S_COMMIT: begin
            active_half_d = ~active_half_q;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         page_cnt_q    <= '0;
         active_half_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         page_cnt_q    <= page_cnt_d;
         active_half_q <= active_half_d;
      end
   end

   // Storage carries no reset; only the shadow half is ever written.
   always_ff @(posedge write_clk) begin
      if (beat_we) begin
         for (int b = 0; b < BANK_NUM; b++) begin
            mem_q[b][~active_half_q][page_cnt_q] <= load_data[b*QUAN_SIZE +: QUAN_SIZE];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < READ_PORT_NUM; p++) begin
         rd_bank[p] = rd_bank_addr[p*BANK_BW +: BANK_BW];
         rd_page[p] = rd_page_addr[p*PAGE_ADDR_BW +: PAGE_ADDR_BW];
         rd_word[p] = '0;
         if ({1'b0, rd_bank[p]} < BANK_LIM) begin
            rd_word[p] = mem_q[rd_bank[p]][active_half_q][rd_page[p]];
         end
      end
   end

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         for (int p = 0; p < READ_PORT_NUM; p++) begin
            lut_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < READ_PORT_NUM; p++) begin
            if (rd_en[p]) begin
               lut_q[p] <= rd_word[p];
            end
         end
      end
   end

   for (genvar p = 0; p < READ_PORT_NUM; p++) begin : g_rd_out
      assign lut_data[p*QUAN_SIZE +: QUAN_SIZE] = lut_q[p];
   end

   assign load_ready  = (state_q == S_LOAD);
   assign load_done   = (state_q == S_COMMIT);
   assign busy        = (state_q != S_IDLE);
   assign active_half = active_half_q;

endmodule

// File: tb/tb_sym_vn_rank_dbuf.sv
// Bench for sym_vn_rank_dbuf (3 banks, 4 read ports): reads are scored against a
// bench-side copy of both LUT halves that is updated as beats are accepted.
module tb_sym_vn_rank_dbuf;

   localparam int Q   = 4;
   localparam int PAW = 6;
   localparam int BN  = 3;
   localparam int BBW = 2;
   localparam int RPN = 4;
   localparam int PN  = 64;

   logic                 write_clk = 1'b0;
   logic                 rstn;
   logic [RPN-1:0]       rd_en;
   logic [RPN*BBW-1:0]   rd_bank_addr;
   logic [RPN*PAW-1:0]   rd_page_addr;
   logic [RPN*Q-1:0]     lut_data;
   logic                 load_start;
   logic                 load_abort;
   logic                 load_valid;
   logic [BN*Q-1:0]      load_data;
   logic                 load_ready;
   logic                 load_done;
   logic                 active_half;
   logic                 busy;

   always #5 write_clk = ~write_clk;

   sym_vn_rank_dbuf #(
      .QUAN_SIZE    (Q),
      .PAGE_ADDR_BW (PAW),
      .BANK_NUM     (BN),
      .BANK_BW      (BBW),
      .READ_PORT_NUM(RPN)
   ) dut (
      .write_clk    (write_clk),
      .rstn         (rstn),
      .rd_en        (rd_en),
      .rd_bank_addr (rd_bank_addr),
      .rd_page_addr (rd_page_addr),
      .lut_data     (lut_data),
      .load_start   (load_start),
      .load_abort   (load_abort),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .load_done    (load_done),
      .active_half  (active_half),
      .busy         (busy)
   );

   typedef struct {
      int             port;
      int             bank;
      int             page;
      logic [Q-1:0]   exp;
   } rd_exp_t;

   rd_exp_t        sb[$];
   logic [Q-1:0]   model [BN][2][PN];
   logic           exp_half;
   int             checks   = 0;
   int             failures = 0;

   task automatic step();
      @(posedge write_clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_en      = '0;
      load_start = 1'b0;
      load_abort = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
   endtask

   task automatic issue_rd(input int p, input int bank, input int page, input logic [Q-1:0] exp);
      rd_en[p]                     = 1'b1;
      rd_bank_addr[p*BBW +: BBW]   = bank[BBW-1:0];
      rd_page_addr[p*PAW +: PAW]   = page[PAW-1:0];
      sb.push_back('{port: p, bank: bank, page: page, exp: exp});
   endtask

   function automatic logic [Q-1:0] mexp(input int bank, input int page, input logic half);
      if (bank >= BN) return '0;
      return model[bank][half][page];
   endfunction

   function automatic logic [Q-1:0] pat(input int kind, input int b, input int pg);
      int t;
      case (kind)
         0:       t = (b == 0) ? pg : (b == 1) ? ~pg : (pg ^ 6);
         1:       t = (b == 0) ? (pg + 3) : (b == 1) ? ~(pg + 3) : ((pg + 3) ^ 9);
         2:       t = int'($urandom_range(0, 15));
         default: t = pg * 7 + b * 5;
      endcase
      return t[Q-1:0];
   endfunction

   // Full load of the shadow half; optional throttling and background reads.
   task automatic do_load(input int kind, input bit throttle, input bit rd_during);
      int      page;
      int      cyc;
      int      rp;
      logic    v;
      logic    old;
      rd_exp_t e;
      old  = exp_half;
      page = 0;
      cyc  = 0;
      idle_inputs();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      checks++;
      if ({busy, load_ready, load_done} !== 3'b110) begin
         failures++;
         $display("FAIL load_enter busy/ready/done got=%b exp=110", {busy, load_ready, load_done});
      end
      while (page < PN && cyc < 1000) begin
         v          = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         load_valid = v;
         load_start = (cyc == 20);
         for (int b = 0; b < BN; b++) load_data[b*Q +: Q] = pat(kind, b, page);
         rd_en = '0;
         if (rd_during) begin
            rp = $urandom_range(0, PN-1);
            issue_rd(0, 0, rp, mexp(0, rp, old));
            rp = $urandom_range(0, PN-1);
            issue_rd(1, 1, rp, mexp(1, rp, old));
         end
         step();
         cyc++;
         if (v) begin
            for (int b = 0; b < BN; b++) model[b][!old][page] = load_data[b*Q +: Q];
            page++;
         end
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (lut_data[e.port*Q +: Q] !== e.exp) begin
               failures++;
               $display("FAIL load_rd port=%0d bank=%0d page=%0d got=%h exp=%h",
                        e.port, e.bank, e.page, lut_data[e.port*Q +: Q], e.exp);
            end
         end
         if (page < PN) begin
            checks++;
            if ({busy, load_ready, load_done, active_half} !== {3'b110, old}) begin
               failures++;
               $display("FAIL load_mid busy/ready/done/half got=%b exp=%b",
                        {busy, load_ready, load_done, active_half}, {3'b110, old});
            end
         end
      end
      if (page < PN) begin
         failures++;
         $display("FAIL load_timeout accepted=%0d required=%0d", page, PN);
      end
      load_valid = 1'b0;
      load_start = 1'b0;
      rd_en      = '0;
      checks++;
      if ({busy, load_ready, load_done, active_half} !== {3'b101, old}) begin
         failures++;
         $display("FAIL commit busy/ready/done/half got=%b exp=%b",
                  {busy, load_ready, load_done, active_half}, {3'b101, old});
      end
      load_abort = 1'b1;
      issue_rd(0, 0, 2, mexp(0, 2, old));
      step();
      load_abort = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lut_data[e.port*Q +: Q] !== e.exp) begin
            failures++;
            $display("FAIL commit_rd port=%0d page=%0d got=%h exp=%h",
                     e.port, e.page, lut_data[e.port*Q +: Q], e.exp);
         end
      end
      exp_half = !old;
      checks++;
      if ({busy, load_ready, load_done, active_half} !== {3'b000, exp_half}) begin
         failures++;
         $display("FAIL swap busy/ready/done/half got=%b exp=%b",
                  {busy, load_ready, load_done, active_half}, {3'b000, exp_half});
      end
      rd_en = '0;
      issue_rd(0, 0, 2, mexp(0, 2, exp_half));
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lut_data[e.port*Q +: Q] !== e.exp) begin
            failures++;
            $display("FAIL post_swap_rd port=%0d page=%0d got=%h exp=%h",
                     e.port, e.page, lut_data[e.port*Q +: Q], e.exp);
         end
      end
      rd_en = '0;
   endtask

   // Every page of every bank, plus the out-of-range bank on port 3.
   task automatic verify_all();
      rd_exp_t e;
      for (int pg = 0; pg < PN; pg++) begin
         rd_en = '0;
         for (int p = 0; p < RPN; p++) issue_rd(p, p, pg, mexp(p, pg, exp_half));
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (lut_data[e.port*Q +: Q] !== e.exp) begin
               failures++;
               $display("FAIL verify port=%0d bank=%0d page=%0d got=%h exp=%h",
                        e.port, e.bank, e.page, lut_data[e.port*Q +: Q], e.exp);
            end
         end
      end
      rd_en = '0;
   endtask

   task automatic test_reset_then_load();
      rd_exp_t e;
      rstn         = 1'b0;
      rd_bank_addr = '0;
      rd_page_addr = '0;
      idle_inputs();
      repeat (3) step();
      checks++;
      if (lut_data !== '0) begin
         failures++;
         $display("FAIL reset_lut got=%h exp=0", lut_data);
      end
      checks++;
      if ({busy, load_ready, load_done, active_half} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl busy/ready/done/half got=%b exp=0000",
                  {busy, load_ready, load_done, active_half});
      end
      rstn     = 1'b1;
      exp_half = 1'b0;
      step();
      do_load(0, 1'b0, 1'b0);
      issue_rd(0, 0, 5, 4'h5);
      issue_rd(1, 1, 5, 4'hA);
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lut_data[e.port*Q +: Q] !== e.exp) begin
            failures++;
            $display("FAIL first_load_rd port=%0d got=%h exp=%h", e.port, lut_data[e.port*Q +: Q], e.exp);
         end
      end
      rd_en = '0;
   endtask

   task automatic test_boundary_reads();
      rd_exp_t      e;
      logic [Q-1:0] hold;
      rd_en = '0;
      hold  = mexp(2, 63, exp_half);
      for (int p = 0; p < RPN; p++) issue_rd(p, 2, 63, hold);
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lut_data[e.port*Q +: Q] !== e.exp) begin
            failures++;
            $display("FAIL same_page port=%0d got=%h exp=%h", e.port, lut_data[e.port*Q +: Q], e.exp);
         end
      end
      rd_en        = '0;
      rd_bank_addr = '0;
      rd_page_addr = '0;
      repeat (2) step();
      checks++;
      if (lut_data !== {RPN{hold}}) begin
         failures++;
         $display("FAIL rd_hold got=%h exp=%h", lut_data, {RPN{hold}});
      end
      issue_rd(0, 0, 7, mexp(0, 7, exp_half));
      issue_rd(1, 2, 1, mexp(2, 1, exp_half));
      issue_rd(2, 3, 7, 4'h0);
      issue_rd(3, 3, 0, 4'h0);
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lut_data[e.port*Q +: Q] !== e.exp) begin
            failures++;
            $display("FAIL bank_range port=%0d bank=%0d got=%h exp=%h",
                     e.port, e.bank, lut_data[e.port*Q +: Q], e.exp);
         end
      end
      rd_en = '0;
   endtask

   task automatic test_concurrent();
      rd_exp_t e;
      do_load(1, 1'b0, 1'b1);
      issue_rd(0, 0, 2, 4'h5);
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lut_data[e.port*Q +: Q] !== e.exp) begin
            failures++;
            $display("FAIL pattern_b port=%0d got=%h exp=%h", e.port, lut_data[e.port*Q +: Q], e.exp);
         end
      end
      rd_en = '0;
   endtask

   task automatic test_abort();
      logic old;
      old = exp_half;
      idle_inputs();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int pg = 0; pg < 10; pg++) begin
         load_valid = 1'b1;
         for (int b = 0; b < BN; b++) load_data[b*Q +: Q] = pat(3, b, pg);
         step();
         for (int b = 0; b < BN; b++) model[b][!old][pg] = load_data[b*Q +: Q];
      end
      load_valid = 1'b1;
      load_abort = 1'b1;
      for (int b = 0; b < BN; b++) load_data[b*Q +: Q] = pat(3, b, 10);
      step();
      idle_inputs();
      checks++;
      if ({busy, load_ready, load_done, active_half} !== {3'b000, old}) begin
         failures++;
         $display("FAIL abort busy/ready/done/half got=%b exp=%b",
                  {busy, load_ready, load_done, active_half}, {3'b000, old});
      end
      repeat (3) step();
      checks++;
      if ({busy, load_done, active_half} !== {2'b00, old}) begin
         failures++;
         $display("FAIL abort_settle busy/done/half got=%b exp=%b",
                  {busy, load_done, active_half}, {2'b00, old});
      end
      verify_all();
      do_load(3, 1'b0, 1'b0);
      verify_all();
   endtask

   task automatic test_async_reset();
      int      page;
      logic    old;
      rd_exp_t e;
      old  = exp_half;
      page = 0;
      idle_inputs();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      while (page < 30) begin
         load_valid = 1'b1;
         for (int b = 0; b < BN; b++) load_data[b*Q +: Q] = pat(2, b, page);
         rd_en = '0;
         issue_rd(0, 1, 0, mexp(1, 0, old));
         step();
         for (int b = 0; b < BN; b++) model[b][!old][page] = load_data[b*Q +: Q];
         page++;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (lut_data[e.port*Q +: Q] !== e.exp) begin
               failures++;
               $display("FAIL async_pre_rd port=%0d got=%h exp=%h", e.port, lut_data[e.port*Q +: Q], e.exp);
            end
         end
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({busy, load_ready, load_done, active_half} !== 4'b0000) begin
         failures++;
         $display("FAIL async_ctrl busy/ready/done/half got=%b exp=0000",
                  {busy, load_ready, load_done, active_half});
      end
      checks++;
      if (lut_data !== '0) begin
         failures++;
         $display("FAIL async_lut got=%h exp=0", lut_data);
      end
      idle_inputs();
      repeat (2) step();
      rstn     = 1'b1;
      exp_half = 1'b0;
      step();
      checks++;
      if ({busy, load_ready, active_half} !== 3'b000) begin
         failures++;
         $display("FAIL async_release busy/ready/half got=%b exp=000", {busy, load_ready, active_half});
      end
      do_load(0, 1'b0, 1'b0);
      verify_all();
   endtask

   task automatic test_throttled();
      do_load(2, 1'b1, 1'b1);
      verify_all();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset_then_load();
      test_boundary_reads();
      test_concurrent();
      test_abort();
      test_async_reset();
      test_throttled();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
